// File: rtl/nibble_seq_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state encoding and nibble width.
package nibble_seq_pkg;

    localparam int NIBBLE_W = 4;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

endpackage

// File: rtl/nibble_adder.sv
// 4-bit combinational ripple-carry adder; the only arithmetic datapath of nibble_add_seq.
module nibble_adder
    import nibble_seq_pkg::*;
(
    input  logic                cin,
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    logic [NIBBLE_W:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < NIBBLE_W; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
        cout = c[NIBBLE_W];
    end

endmodule

// File: rtl/nibble_add_seq.sv
// Nibble-serial adder: one shared 4-bit adder, one nibble per cycle, NIBBLES+2 cycles per operation.
// Optional subtract mode (a + ~b + 1) enabled by macro NIBBLE_ADD_SEQ_SUB_EN.
module nibble_add_seq
    import nibble_seq_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    input  logic                        sub,
`endif
    input  logic [NIBBLE_W*NIBBLES-1:0] a,
    input  logic [NIBBLE_W*NIBBLES-1:0] b,
    input  logic                        cin,
    output logic                        busy,
    output logic                        done,
    output logic [NIBBLE_W*NIBBLES-1:0] sum,
    output logic                        cout,
    output logic                        ovf
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = 3;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [NIBBLE_W-1:0] nib_a, nib_b, add_s;
    logic                add_c;

    // Operand nibble select by constant-indexed mux so no index arithmetic is inferred
    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib_a = a_q[i*NIBBLE_W +: NIBBLE_W];
                nib_b = b_q[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    nibble_adder u_adder (
        .cin  (carry_q),
        .a    (nib_a),
        .b    (nib_b),
        .sum  (add_s),
        .cout (add_c)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
                    // Subtraction stores ~b and forces carry-in, so RUN stays a plain add
                    if (sub) begin
                        b_d     = ~b;
                        carry_d = 1'b1;
                    end
`endif
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int unsigned i = 0; i < NIBBLES; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        sum_d[i*NIBBLE_W +: NIBBLE_W] = add_s;
                    end
                end
                carry_d = add_c;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(NIBBLES - 1)) begin
                    cout_d  = add_c;
                    // Carry into the MSB equals a^b^s at that bit
                    ovf_d   = nib_a[NIBBLE_W-1] ^ nib_b[NIBBLE_W-1] ^ add_s[NIBBLE_W-1] ^ add_c;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: doc/nibble_add_seq.md
NIBBLE_ADD_SEQ -- requirements
Module: nibble_add_seq

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, giving the operand width in 4-bit nibbles (operand width W = 4*NIBBLES, legal range 2..8).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1 bit, request to begin one addition; sampled only in IDLE.
REQ-005 SHALL have ports a and b, input, W bits each, the operands; sampled on the accepted start cycle.
REQ-006 SHALL have port cin, input, 1 bit, the carry-in to nibble 0; sampled on the accepted start cycle.
REQ-007 SHALL have port busy, output, 1 bit, high while in RUN.
REQ-008 SHALL have port done, output, 1 bit, a one-cycle pulse when the result is valid.
REQ-009 SHALL have port sum, output, W bits, the registered result.
REQ-010 SHALL have port cout, output, 1 bit, the registered carry out of the top nibble.
REQ-011 SHALL have port ovf, output, 1 bit, registered signed overflow (carry into MSB XOR carry out of MSB).

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE.
REQ-013 In IDLE with start=1, SHALL latch a, b and cin, set nibble index to 0, clear sum, and go to RUN.
REQ-014 In RUN, each cycle SHALL add nibble[idx] of a and b plus the carry register through one shared 4-bit adder, write sum[4*idx+3:4*idx], update the carry register and increment idx.
REQ-015 In RUN with idx = NIBBLES-1, SHALL store the final carry into cout, compute ovf and go to DONE.
REQ-016 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-017 Latency: with start accepted at edge 0, busy SHALL be high for cycles 1..NIBBLES and done SHALL be high in cycle NIBBLES+1.
REQ-018 start SHALL be ignored in RUN and DONE; no queuing and no operand re-sampling.
REQ-019 start asserted in the cycle after DONE (IDLE) SHALL be accepted normally, allowing back-to-back operations every NIBBLES+2 cycles.
REQ-020 sum, cout and ovf SHALL hold their last result from DONE until the next accepted start.
REQ-021 Changes to a, b and cin after acceptance SHALL NOT affect the result in progress.
REQ-022 Arithmetic SHALL be modulo 2^W, with cout carrying the (W+1)th bit.

Reset
REQ-023 reset SHALL force state IDLE, idx=0, carry=0, sum=0, cout=0, ovf=0, busy=0 and done=0 on the next edge.
REQ-024 reset SHALL take priority over start and over any in-flight RUN/DONE; a partial result SHALL be discarded.

Configuration
REQ-025 Macro NIBBLE_ADD_SEQ_SUB_EN SHALL add an input port sub (1 bit), sampled with start.
REQ-026 With NIBBLE_ADD_SEQ_SUB_EN defined and sub=1, the block SHALL compute a - b as a + ~b + 1, ignoring cin; cout=1 then means no borrow.
REQ-027 Without NIBBLE_ADD_SEQ_SUB_EN, the sub port SHALL NOT exist and the block SHALL only add.

Structure
REQ-028 Package nibble_seq_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and the constant NIBBLE_W=4.
REQ-029 The 4-bit combinational ripple adder SHALL be a separate sub-module, nibble_adder (cin, a[3:0], b[3:0] -> sum[3:0], cout), instantiated exactly once.
REQ-030 No other arithmetic SHALL be inferred outside nibble_adder except the idx increment.

Verification
REQ-031 NIBBLES=4: a=0x1234, b=0x4321, cin=0, start at edge 0 -> done in cycle 5, sum=0x5555, cout=0, ovf=0.
REQ-032 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
REQ-033 start pulsed again, and a/b changed, during RUN -> no effect; the first result is unchanged and only one done pulse occurs.
REQ-034 reset asserted in the second RUN cycle -> next cycle busy=0, sum=0, and no done pulse; a following start runs normally.
REQ-035 With NIBBLE_ADD_SEQ_SUB_EN, sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0; a=0x0007, b=0x0005 -> sum=0x0002, cout=1.
REQ-036 Back-to-back: start high continuously -> an operation is accepted every NIBBLES+2 cycles, each with correct sum.
